// File: rtl/qspi_axil_arbiter_if.sv
// AXI4-Lite bus bundle shared by both upstream ports and the downstream port.
// Modport s faces an upstream master; modport m faces the downstream slave.
interface axi4_lite_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic [AW-1:0]   awaddr;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport s (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport m (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/qspi_axil_arbiter.sv
// Two-port AXI4-Lite arbiter onto the QSPI register bus: one outstanding transaction,
// round-robin between ports, write/read alternation per port, DECERR for out-of-window.
module qspi_axil_arbiter #(
   parameter int DW      = 32,
   parameter int AW      = 32,
   parameter int SPAN_AW = 10
) (
   input  logic       aclk,
   input  logic       aresetn,
   axi4_lite_if.s     s0_bus,
   axi4_lite_if.s     s1_bus,
   axi4_lite_if.m     m_bus,
   output logic       busy,
   output logic [1:0] grant
);
   typedef enum logic [2:0] {
      IDLE, WR_FWD, WR_RESP, RD_FWD, RD_RESP, ERR_WR, ERR_RD
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [1:0]      r_grant;
   logic            r_busy;
   logic            r_last;
   logic [1:0]      r_prev_wr;
   logic            r_aw_done, r_w_done, r_err_ph;

   logic            w_wreq0, w_wreq1, w_rreq0, w_rreq1, w_req0, w_req1;
   logic            w_port, w_sel_wr, w_oow;
   logic [AW-1:0]   w_req_addr;

   logic            w_g;
   logic            w_g_awvalid, w_g_wvalid, w_g_arvalid, w_g_bready, w_g_rready;
   logic            w_m_awvalid, w_m_wvalid, w_m_bready, w_m_arvalid, w_m_rready;
   logic            w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
   logic            w_g_awready, w_g_wready, w_g_bvalid, w_g_arready, w_g_rvalid;
   logic [1:0]      w_g_bresp, w_g_rresp;
   logic [DW-1:0]   w_g_rdata;

   assign w_wreq0 = s0_bus.awvalid && s0_bus.wvalid;
   assign w_wreq1 = s1_bus.awvalid && s1_bus.wvalid;
   assign w_rreq0 = s0_bus.arvalid;
   assign w_rreq1 = s1_bus.arvalid;
   assign w_req0  = w_wreq0 || w_rreq0;
   assign w_req1  = w_wreq1 || w_rreq1;

   // On a tie the port that was not served last wins; otherwise the lone requester.
   assign w_port   = (w_req0 && w_req1) ? !r_last : w_req1;
   assign w_sel_wr = w_port ? (w_wreq1 && !(r_prev_wr[1] && w_rreq1))
                            : (w_wreq0 && !(r_prev_wr[0] && w_rreq0));
   assign w_req_addr = w_port ? (w_sel_wr ? s1_bus.awaddr : s1_bus.araddr)
                              : (w_sel_wr ? s0_bus.awaddr : s0_bus.araddr);
   assign w_oow = |w_req_addr[AW-1:SPAN_AW];

   assign w_g         = r_grant[1];
   assign w_g_awvalid = w_g ? s1_bus.awvalid : s0_bus.awvalid;
   assign w_g_wvalid  = w_g ? s1_bus.wvalid  : s0_bus.wvalid;
   assign w_g_arvalid = w_g ? s1_bus.arvalid : s0_bus.arvalid;
   assign w_g_bready  = w_g ? s1_bus.bready  : s0_bus.bready;
   assign w_g_rready  = w_g ? s1_bus.rready  : s0_bus.rready;

   assign m_bus.awaddr = w_g ? s1_bus.awaddr : s0_bus.awaddr;
   assign m_bus.awprot = w_g ? s1_bus.awprot : s0_bus.awprot;
   assign m_bus.wdata  = w_g ? s1_bus.wdata  : s0_bus.wdata;
   assign m_bus.wstrb  = w_g ? s1_bus.wstrb  : s0_bus.wstrb;
   assign m_bus.araddr = w_g ? s1_bus.araddr : s0_bus.araddr;
   assign m_bus.arprot = w_g ? s1_bus.arprot : s0_bus.arprot;

   assign w_aw_hs = w_m_awvalid && m_bus.awready;
   assign w_w_hs  = w_m_wvalid  && m_bus.wready;
   assign w_ar_hs = w_m_arvalid && m_bus.arready;
   assign w_b_hs  = m_bus.bvalid && w_g_bready;
   assign w_r_hs  = m_bus.rvalid && w_g_rready;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_req0 || w_req1) begin
               if (w_sel_wr) w_state_nxt = w_oow ? ERR_WR : WR_FWD;
               else          w_state_nxt = w_oow ? ERR_RD : RD_FWD;
            end
         end
         WR_FWD:  if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = WR_RESP;
         WR_RESP: if (w_b_hs) w_state_nxt = IDLE;
         RD_FWD:  if (w_ar_hs) w_state_nxt = RD_RESP;
         RD_RESP: if (w_r_hs) w_state_nxt = IDLE;
         ERR_WR:  if (r_err_ph && w_g_bready) w_state_nxt = IDLE;
         ERR_RD:  if (r_err_ph && w_g_rready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Bus-facing controls; everything is quiet in IDLE so no upstream valid reaches m_bus.
   always_comb begin
      w_m_awvalid = 1'b0;
      w_m_wvalid  = 1'b0;
      w_m_bready  = 1'b0;
      w_m_arvalid = 1'b0;
      w_m_rready  = 1'b0;
      w_g_awready = 1'b0;
      w_g_wready  = 1'b0;
      w_g_bvalid  = 1'b0;
      w_g_bresp   = 2'b00;
      w_g_arready = 1'b0;
      w_g_rvalid  = 1'b0;
      w_g_rdata   = '0;
      w_g_rresp   = 2'b00;
      case (r_state)
         WR_FWD: begin
            w_m_awvalid = w_g_awvalid && !r_aw_done;
            w_m_wvalid  = w_g_wvalid  && !r_w_done;
            w_g_awready = m_bus.awready && !r_aw_done;
            w_g_wready  = m_bus.wready  && !r_w_done;
         end
         WR_RESP: begin
            w_m_bready = w_g_bready;
            w_g_bvalid = m_bus.bvalid;
            w_g_bresp  = m_bus.bresp;
         end
         RD_FWD: begin
            w_m_arvalid = w_g_arvalid;
            w_g_arready = m_bus.arready;
         end
         RD_RESP: begin
            w_m_rready = w_g_rready;
            w_g_rvalid = m_bus.rvalid;
            w_g_rdata  = m_bus.rdata;
            w_g_rresp  = m_bus.rresp;
         end
         ERR_WR: begin
            w_g_awready = !r_err_ph;
            w_g_wready  = !r_err_ph;
            w_g_bvalid  = r_err_ph;
            w_g_bresp   = r_err_ph ? 2'b11 : 2'b00;
         end
         ERR_RD: begin
            w_g_arready = !r_err_ph;
            w_g_rvalid  = r_err_ph;
            w_g_rresp   = r_err_ph ? 2'b11 : 2'b00;
         end
         default: ;
      endcase
   end

   assign m_bus.awvalid = w_m_awvalid;
   assign m_bus.wvalid  = w_m_wvalid;
   assign m_bus.bready  = w_m_bready;
   assign m_bus.arvalid = w_m_arvalid;
   assign m_bus.rready  = w_m_rready;

   assign s0_bus.awready = r_grant[0] && w_g_awready;
   assign s0_bus.wready  = r_grant[0] && w_g_wready;
   assign s0_bus.bvalid  = r_grant[0] && w_g_bvalid;
   assign s0_bus.bresp   = r_grant[0] ? w_g_bresp : 2'b00;
   assign s0_bus.arready = r_grant[0] && w_g_arready;
   assign s0_bus.rvalid  = r_grant[0] && w_g_rvalid;
   assign s0_bus.rdata   = r_grant[0] ? w_g_rdata : '0;
   assign s0_bus.rresp   = r_grant[0] ? w_g_rresp : 2'b00;

   assign s1_bus.awready = r_grant[1] && w_g_awready;
   assign s1_bus.wready  = r_grant[1] && w_g_wready;
   assign s1_bus.bvalid  = r_grant[1] && w_g_bvalid;
   assign s1_bus.bresp   = r_grant[1] ? w_g_bresp : 2'b00;
   assign s1_bus.arready = r_grant[1] && w_g_arready;
   assign s1_bus.rvalid  = r_grant[1] && w_g_rvalid;
   assign s1_bus.rdata   = r_grant[1] ? w_g_rdata : '0;
   assign s1_bus.rresp   = r_grant[1] ? w_g_rresp : 2'b00;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state   <= IDLE;
         r_grant   <= 2'b00;
         r_busy    <= 1'b0;
         r_last    <= 1'b1;
         r_prev_wr <= 2'b00;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_err_ph  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != IDLE);
         if (r_state == IDLE && w_state_nxt != IDLE) begin
            r_grant           <= w_port ? 2'b10 : 2'b01;
            r_last            <= w_port;
            r_prev_wr[w_port] <= w_sel_wr;
         end else if (w_state_nxt == IDLE) begin
            r_grant <= 2'b00;
         end
         // Phase flags live only within one state and restart on every transition.
         if (w_state_nxt != r_state) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err_ph  <= 1'b0;
         end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (r_state == ERR_WR || r_state == ERR_RD) r_err_ph <= 1'b1;
         end
      end
   end

   assign busy  = r_busy;
   assign grant = r_grant;
endmodule

// File: tb/tb_qspi_axil_arbiter.sv
// Directed bench for qspi_axil_arbiter: the bench plays both upstream masters and the
// downstream slave, stepping one clock at a time against hand-computed expectations.
module tb_qspi_axil_arbiter;
   logic       aclk = 1'b0;
   logic       aresetn;
   logic       busy;
   logic [1:0] grant;
   int         checks = 0;
   int         errors = 0;

   axi4_lite_if #(.DW(32), .AW(32)) s0_if ();
   axi4_lite_if #(.DW(32), .AW(32)) s1_if ();
   axi4_lite_if #(.DW(32), .AW(32)) m_if ();

   qspi_axil_arbiter #(.DW(32), .AW(32), .SPAN_AW(10)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s0_bus  (s0_if),
      .s1_bus  (s1_if),
      .m_bus   (m_if),
      .busy    (busy),
      .grant   (grant)
   );

   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic clr_inputs();
      s0_if.awaddr = '0; s0_if.awprot = '0; s0_if.awvalid = 0; s0_if.wdata = '0;
      s0_if.wstrb = '0; s0_if.wvalid = 0; s0_if.bready = 0; s0_if.araddr = '0;
      s0_if.arprot = '0; s0_if.arvalid = 0; s0_if.rready = 0;
      s1_if.awaddr = '0; s1_if.awprot = '0; s1_if.awvalid = 0; s1_if.wdata = '0;
      s1_if.wstrb = '0; s1_if.wvalid = 0; s1_if.bready = 0; s1_if.araddr = '0;
      s1_if.arprot = '0; s1_if.arvalid = 0; s1_if.rready = 0;
      m_if.awready = 0; m_if.wready = 0; m_if.bresp = 2'b00; m_if.bvalid = 0;
      m_if.arready = 0; m_if.rdata = '0; m_if.rresp = 2'b00; m_if.rvalid = 0;
   endtask

   initial begin
      clr_inputs();
      aresetn = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_m_ctl", {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready}, 0);
      chk("rst_s0_ctl", {s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid}, 0);
      chk("rst_s1_ctl", {s1_if.awready, s1_if.wready, s1_if.bvalid, s1_if.arready, s1_if.rvalid}, 0);
      tick();
      tick();
      aresetn = 1'b1;
      m_if.awready = 1; m_if.wready = 1; m_if.arready = 1;

      // Contention: both ports read at once; port 0 wins first tie after reset.
      s0_if.araddr = 32'h10; s0_if.arvalid = 1; s0_if.rready = 1;
      s1_if.araddr = 32'h20; s1_if.arvalid = 1; s1_if.rready = 1;
      #1;
      chk("idle_no_comb_path", m_if.arvalid, 0);
      tick();
      chk("cont_grant0", grant, 2'b01);
      chk("cont_busy", busy, 1);
      chk("cont_m_arvalid", m_if.arvalid, 1);
      chk("cont_m_araddr0", m_if.araddr, 32'h10);
      chk("cont_s0_arready", s0_if.arready, 1);
      chk("cont_s1_arready", s1_if.arready, 0);
      tick();
      s0_if.arvalid = 0;
      m_if.rvalid = 1; m_if.rdata = 32'h1111_0010;
      #1;
      chk("cont_s0_rvalid", s0_if.rvalid, 1);
      chk("cont_s0_rdata", s0_if.rdata, 32'h1111_0010);
      chk("cont_s1_rvalid", s1_if.rvalid, 0);
      chk("cont_s1_rdata", s1_if.rdata, 0);
      tick();
      m_if.rvalid = 0;
      chk("cont_idle_grant", grant, 2'b00);
      chk("cont_idle_busy", busy, 0);
      tick();
      chk("cont_grant1", grant, 2'b10);
      chk("cont_m_araddr1", m_if.araddr, 32'h20);
      tick();
      s1_if.arvalid = 0;
      m_if.rvalid = 1; m_if.rdata = 32'h2222_0020;
      #1;
      chk("cont_s1_rdata2", s1_if.rdata, 32'h2222_0020);
      chk("cont_s0_rdata2", s0_if.rdata, 0);
      tick();
      m_if.rvalid = 0;

      // Single in-window write from port 0.
      s0_if.awaddr = 32'h004; s0_if.awvalid = 1; s0_if.wdata = 32'hA5A5_0001;
      s0_if.wstrb = 4'hF; s0_if.wvalid = 1; s0_if.bready = 1;
      tick();
      chk("wr_grant", grant, 2'b01);
      chk("wr_m_valids", {m_if.awvalid, m_if.wvalid}, 2'b11);
      chk("wr_m_awaddr", m_if.awaddr, 32'h004);
      chk("wr_m_wdata", m_if.wdata, 32'hA5A5_0001);
      chk("wr_m_wstrb", m_if.wstrb, 4'hF);
      chk("wr_s0_readies", {s0_if.awready, s0_if.wready}, 2'b11);
      chk("wr_s1_readies", {s1_if.awready, s1_if.wready, s1_if.arready}, 0);
      tick();
      s0_if.awvalid = 0; s0_if.wvalid = 0;
      m_if.bvalid = 1; m_if.bresp = 2'b00;
      #1;
      chk("wr_s0_bvalid", s0_if.bvalid, 1);
      chk("wr_s0_bresp", s0_if.bresp, 2'b00);
      chk("wr_m_bready", m_if.bready, 1);
      chk("wr_resp_m_awvalid", m_if.awvalid, 0);
      tick();
      m_if.bvalid = 0;
      chk("wr_done_busy", busy, 0);

      // Port 1: AW three cycles ahead of W; no grant until both are present.
      m_if.wready = 0;
      s1_if.awaddr = 32'h008; s1_if.awvalid = 1; s1_if.wdata = 32'hDEAD_0008;
      s1_if.wstrb = 4'h3; s1_if.bready = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("awfirst_nogrant", grant, 0);
         chk("awfirst_m_awvalid", m_if.awvalid, 0);
      end
      s1_if.wvalid = 1;
      tick();
      chk("awfirst_grant", grant, 2'b10);
      chk("awfirst_m_valids", {m_if.awvalid, m_if.wvalid}, 2'b11);
      tick();
      s1_if.awvalid = 0;
      #1;
      chk("awfirst_aw_done", {m_if.awvalid, m_if.wvalid}, 2'b01);
      chk("awfirst_wready_lo", s1_if.wready, 0);
      m_if.wready = 1;
      #1;
      chk("awfirst_wready_hi", s1_if.wready, 1);
      chk("awfirst_m_wdata", m_if.wdata, 32'hDEAD_0008);
      tick();
      s1_if.wvalid = 0;
      m_if.bvalid = 1;
      tick();
      m_if.bvalid = 0;
      chk("awfirst_idle", busy, 0);

      // Out-of-window read: answered locally, nothing downstream.
      s0_if.araddr = 32'h0000_0400; s0_if.arvalid = 1; s0_if.rready = 1;
      tick();
      chk("oowr_grant", grant, 2'b01);
      chk("oowr_arready", s0_if.arready, 1);
      chk("oowr_m_arvalid", m_if.arvalid, 0);
      tick();
      s0_if.arvalid = 0;
      #1;
      chk("oowr_arready_pulse", s0_if.arready, 0);
      chk("oowr_rvalid", s0_if.rvalid, 1);
      chk("oowr_rresp", s0_if.rresp, 2'b11);
      chk("oowr_rdata", s0_if.rdata, 0);
      chk("oowr_m_arvalid2", m_if.arvalid, 0);
      tick();
      chk("oowr_idle", busy, 0);

      // Out-of-window write with a late bready.
      s0_if.awaddr = 32'h8000_0000; s0_if.awvalid = 1; s0_if.wvalid = 1; s0_if.bready = 0;
      tick();
      chk("ooww_readies", {s0_if.awready, s0_if.wready}, 2'b11);
      chk("ooww_m_valids", {m_if.awvalid, m_if.wvalid}, 0);
      tick();
      s0_if.awvalid = 0; s0_if.wvalid = 0;
      #1;
      chk("ooww_readies_pulse", {s0_if.awready, s0_if.wready}, 0);
      chk("ooww_bvalid", s0_if.bvalid, 1);
      chk("ooww_bresp", s0_if.bresp, 2'b11);
      tick();
      chk("ooww_bvalid_hold", s0_if.bvalid, 1);
      s0_if.bready = 1;
      tick();
      chk("ooww_idle_grant", grant, 0);

      // Asynchronous reset while in WR_RESP.
      s0_if.awaddr = 32'h0C0; s0_if.awvalid = 1; s0_if.wvalid = 1;
      tick();
      tick();
      s0_if.awvalid = 0; s0_if.wvalid = 0;
      chk("rstmid_busy_before", busy, 1);
      chk("rstmid_m_bready_before", m_if.bready, 1);
      #2;
      aresetn = 1'b0;
      m_if.bvalid = 1;
      #1;
      chk("rstmid_busy", busy, 0);
      chk("rstmid_grant", grant, 0);
      chk("rstmid_s0_ctl", {s0_if.awready, s0_if.wready, s0_if.bvalid, s0_if.arready, s0_if.rvalid}, 0);
      chk("rstmid_m_ctl", {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready}, 0);
      tick();
      aresetn = 1'b1;
      m_if.bvalid = 0;

      // Port 1 holds a write and a read: served W, R, W, R; B held off five cycles.
      s1_if.awaddr = 32'h00C; s1_if.awvalid = 1; s1_if.wdata = 32'h5555_000C;
      s1_if.wvalid = 1; s1_if.araddr = 32'h014; s1_if.arvalid = 1;
      s1_if.bready = 0; s1_if.rready = 1;
      tick();
      chk("alt_w1_grant", grant, 2'b10);
      chk("alt_w1_m", {m_if.awvalid, m_if.arvalid}, 2'b10);
      tick();
      m_if.bvalid = 1; m_if.bresp = 2'b01;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("alt_bready_low", m_if.bready, 0);
         chk("alt_bvalid_held", {s1_if.bvalid, s1_if.bresp}, 3'b101);
         tick();
      end
      s1_if.bready = 1;
      #1;
      chk("alt_b_not_lost", {s1_if.bvalid, s1_if.bresp, m_if.bready}, 4'b1011);
      tick();
      m_if.bvalid = 0; m_if.bresp = 2'b00;
      tick();
      chk("alt_r1_m", {m_if.awvalid, m_if.arvalid}, 2'b01);
      chk("alt_r1_araddr", m_if.araddr, 32'h014);
      tick();
      m_if.rvalid = 1; m_if.rdata = 32'h3333_0014;
      #1;
      chk("alt_r1_rdata", s1_if.rdata, 32'h3333_0014);
      tick();
      m_if.rvalid = 0;
      tick();
      chk("alt_w2_m", {m_if.awvalid, m_if.arvalid}, 2'b10);
      tick();
      m_if.bvalid = 1;
      tick();
      m_if.bvalid = 0;
      tick();
      chk("alt_r2_m", {m_if.awvalid, m_if.arvalid}, 2'b01);
      tick();
      s1_if.awvalid = 0; s1_if.wvalid = 0; s1_if.arvalid = 0;
      m_if.rvalid = 1;
      tick();
      m_if.rvalid = 0;
      chk("alt_end_idle", {busy, grant}, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
